// File: rtl/core_pkg.sv
// Shared decode encodings for the RV32I-subset core: opcodes, immediate/result/ALU selects
// and the packed control bundle carried from D into E.
package core_pkg;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10,
    ImmJ = 2'b11
  } immSrc_e;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } resultSrc_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } aluCtrl_e;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       aluSrc;
    logic       illegal;
    resultSrc_e resultSrc;
    aluCtrl_e   aluControl;
  } ctrl_t;

  // Unsupported funct3 values fall back to add.
  function automatic aluCtrl_e aluDecode(input logic [2:0] funct3, input logic subBit);
    case (funct3)
      3'b000:  return subBit ? AluSub : AluAdd;
      3'b010:  return AluSlt;
      3'b110:  return AluOr;
      3'b111:  return AluAnd;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_hz_if.sv
// D-stage inputs, write-back port, flush/stall handshake and the registered E-stage bundle.
interface decode_stage_hz_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned REG_AW = $clog2(NREGS);

  logic              ValidD;
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;
  logic              StallD;
  logic              ValidE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              JumpE;
  logic              BranchE;
  logic              ALUSrcE;
  logic              IllegalE;
  logic [1:0]        ResultSrcE;
  logic [2:0]        ALUControlE;

  modport master (
    output ValidD, InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  StallD, ValidE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE
  );

  modport slave (
    input  ValidD, InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output StallD, ValidE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE
  );

endinterface

// File: rtl/decode_ctrl.sv
// Combinational main decoder: opcode/funct fields to the control bundle and immediate select.
module decode_ctrl
  import core_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output ctrl_t      ctrl,
  output immSrc_e    immSrc
);

  always_comb begin
    ctrl            = '0;
    ctrl.resultSrc  = ResAlu;
    ctrl.aluControl = AluAdd;
    immSrc          = ImmI;
    unique case (op)
      OpLoad: begin
        ctrl.regWrite  = 1'b1;
        ctrl.aluSrc    = 1'b1;
        ctrl.resultSrc = ResMem;
      end
      OpStore: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        immSrc        = ImmS;
      end
      OpRType: begin
        ctrl.regWrite   = 1'b1;
        ctrl.aluControl = aluDecode(funct3, funct7b5);
      end
      OpIAlu: begin
        // Immediate ALU ops never subtract; bit 30 is immediate data here.
        ctrl.regWrite   = 1'b1;
        ctrl.aluSrc     = 1'b1;
        ctrl.aluControl = aluDecode(funct3, 1'b0);
      end
      OpBeq: begin
        ctrl.branch     = 1'b1;
        ctrl.aluControl = AluSub;
        immSrc          = ImmB;
      end
      OpJal: begin
        ctrl.regWrite  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.resultSrc = ResPc4;
        immSrc         = ImmJ;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/extender.sv
// Immediate sign-extender for the I, S, B and J instruction formats.
module extender
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  input  immSrc_e         immSrc,
  output logic [XLEN-1:0] immExt
);

  always_comb begin
    immExt = '0;
    unique case (immSrc)
      ImmI: immExt = {{(XLEN-12){instr[31]}}, instr[31:20]};
      ImmS: immExt = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      ImmB: immExt = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ: immExt = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immExt = '0;
    endcase
  end

endmodule

// File: rtl/registerFile.sv
// Architectural register file: synchronous write, combinational read with write-through bypass.
module registerFile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned REG_AW  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  localparam bit HasZero = (ZERO_REG != 0);

  logic [XLEN-1:0] regs [NREGS];
  logic            wrEn;
  logic            zero1;
  logic            zero2;

  assign wrEn  = we && !(HasZero && (wa == '0));
  assign zero1 = HasZero && (ra1 == '0);
  assign zero2 = HasZero && (ra2 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = zero1 ? '0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
  assign rd2 = zero2 ? '0 : ((we && (wa == ra2)) ? wd : regs[ra2]);

endmodule

// File: rtl/decode_stage_hz.sv
// ID stage with load-use hazard detection and the ID/EX pipeline register.
module decode_stage_hz
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input logic              clk,
  input logic              rst,
  decode_stage_hz_if.slave bus
);

  localparam int unsigned REG_AW = $clog2(NREGS);

  logic [6:0]        opD;
  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic [REG_AW-1:0] rdD;
  ctrl_t             ctrlD;
  immSrc_e           immSrcD;
  logic [XLEN-1:0]   rd1D;
  logic [XLEN-1:0]   rd2D;
  logic [XLEN-1:0]   immExtD;
  logic              rs1Used;
  logic              rs2Used;
  logic              loadUseHz;
  logic              bubble;

  logic              validE;
  ctrl_t             ctrlE;
  logic [XLEN-1:0]   rd1E;
  logic [XLEN-1:0]   rd2E;
  logic [XLEN-1:0]   immExtE;
  logic [XLEN-1:0]   pcE;
  logic [XLEN-1:0]   pcPlus4E;
  logic [REG_AW-1:0] rs1E;
  logic [REG_AW-1:0] rs2E;
  logic [REG_AW-1:0] rdE;

  assign opD  = bus.InstrD[6:0];
  assign rs1D = bus.InstrD[15 +: REG_AW];
  assign rs2D = bus.InstrD[20 +: REG_AW];
  assign rdD  = bus.InstrD[7 +: REG_AW];

  decode_ctrl u_decode_ctrl (
    .op       (opD),
    .funct3   (bus.InstrD[14:12]),
    .funct7b5 (bus.InstrD[30]),
    .ctrl     (ctrlD),
    .immSrc   (immSrcD)
  );

  registerFile #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_register_file (
    .clk (clk),
    .rst (rst),
    .we  (bus.RegWriteW),
    .wa  (bus.RdW),
    .wd  (bus.ResultW),
    .ra1 (rs1D),
    .ra2 (rs2D),
    .rd1 (rd1D),
    .rd2 (rd2D)
  );

  extender #(
    .XLEN (XLEN)
  ) u_extender (
    .instr  (bus.InstrD[31:7]),
    .immSrc (immSrcD),
    .immExt (immExtD)
  );

  // Undecodable opcodes count as reading rs1 so they wait conservatively behind a load.
  assign rs1Used = (opD != OpJal);
  assign rs2Used = (opD == OpRType) || (opD == OpStore) || (opD == OpBeq);

  assign loadUseHz = validE && (ctrlE.resultSrc == ResMem) && (rdE != '0) &&
                     (((rdE == rs1D) && rs1Used) || ((rdE == rs2D) && rs2Used));

  assign bus.StallD = !rst && loadUseHz && bus.ValidD && !bus.FlushE;
  assign bubble     = bus.FlushE || loadUseHz || !bus.ValidD;

  // On a bubble only the side-effecting controls clear; datapath fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      validE   <= 1'b0;
      ctrlE    <= '0;
      rd1E     <= '0;
      rd2E     <= '0;
      immExtE  <= '0;
      pcE      <= '0;
      pcPlus4E <= '0;
      rs1E     <= '0;
      rs2E     <= '0;
      rdE      <= '0;
    end else if (bubble) begin
      validE         <= 1'b0;
      ctrlE.regWrite <= 1'b0;
      ctrlE.memWrite <= 1'b0;
      ctrlE.jump     <= 1'b0;
      ctrlE.branch   <= 1'b0;
      ctrlE.illegal  <= 1'b0;
    end else begin
      validE   <= 1'b1;
      ctrlE    <= ctrlD;
      rd1E     <= rd1D;
      rd2E     <= rd2D;
      immExtE  <= immExtD;
      pcE      <= bus.PCD;
      pcPlus4E <= bus.PCPlus4D;
      rs1E     <= rs1D;
      rs2E     <= rs2D;
      rdE      <= rdD;
    end
  end

  assign bus.ValidE      = validE;
  assign bus.RD1E        = rd1E;
  assign bus.RD2E        = rd2E;
  assign bus.ImmExtE     = immExtE;
  assign bus.PCE         = pcE;
  assign bus.PCPlus4E    = pcPlus4E;
  assign bus.Rs1E        = rs1E;
  assign bus.Rs2E        = rs2E;
  assign bus.RdE         = rdE;
  assign bus.RegWriteE   = ctrlE.regWrite;
  assign bus.MemWriteE   = ctrlE.memWrite;
  assign bus.JumpE       = ctrlE.jump;
  assign bus.BranchE     = ctrlE.branch;
  assign bus.ALUSrcE     = ctrlE.aluSrc;
  assign bus.IllegalE    = ctrlE.illegal;
  assign bus.ResultSrcE  = ctrlE.resultSrc;
  assign bus.ALUControlE = ctrlE.aluControl;

endmodule
